// File: rtl/lcd_frame_prefetch.sv
// lcd_frame_prefetch: SDRAM burst prefetcher feeding the LCD driver one pixel per request.
// Define LCD_PREFETCH_STATS_EN to add the underflow_cnt and fifo_min_level outputs.
module lcd_frame_prefetch #(
   parameter int          H_DISP        = 800,
   parameter int          V_DISP        = 480,
   parameter int          FRAME_BASE    = 0,
   parameter int          ADDR_W        = 22,
   parameter int          BURST_LEN     = 256,
   parameter int          FIFO_DEPTH    = 1024,
   parameter logic [15:0] UNDERFLOW_RGB = 16'hF800
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lcd_request,
   input  logic              lcd_framesync,
   output logic [15:0]       lcd_data,
   output logic              rd_burst_req,
   output logic [ADDR_W-1:0] rd_burst_addr,
   output logic [9:0]        rd_burst_len,
   input  logic              rd_burst_ack,
   input  logic              rd_data_valid,
   input  logic [15:0]       rd_data,
   input  logic              rd_burst_done,
   output logic              underflow
`ifdef LCD_PREFETCH_STATS_EN
   ,
   output logic [15:0]                  underflow_cnt,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_min_level
`endif
);
   localparam int TOTAL = H_DISP * V_DISP;
   localparam int REM_W = $clog2((TOTAL > BURST_LEN ? TOTAL : BURST_LEN) + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [REM_W-1:0]  TOTAL_R = REM_W'(TOTAL);
   localparam logic [REM_W-1:0]  BURST_R = REM_W'(BURST_LEN);
   localparam logic [LVL_W-1:0]  DEPTH_L = LVL_W'(FIFO_DEPTH);
   localparam logic [LVL_W-1:0]  BURST_L = LVL_W'(BURST_LEN);
   localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(FRAME_BASE);

   typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
   state_t state, state_nx;
   logic fs_q, flush, discard;
   logic [ADDR_W-1:0] next_addr;
   logic [REM_W-1:0] remaining;
   logic [15:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [LVL_W-1:0] level;
   logic empty, push, pop, start, accept;

   assign empty        = level == '0;
   assign push         = state == XFER && rd_data_valid && !discard && !flush;
   assign pop          = lcd_request && !empty;
   assign start        = state == IDLE && remaining != '0 && DEPTH_L - level >= BURST_L && !flush;
   assign accept       = state == REQ && rd_burst_ack;
   assign rd_burst_req = state == REQ;

   always_comb begin
      state_nx = state;
      if (state == IDLE)
         state_nx = start ? REQ : IDLE;
      else if (state == REQ)
         state_nx = rd_burst_ack ? XFER : flush ? IDLE : REQ;
      else
         state_nx = rd_burst_done ? IDLE : XFER;
   end

   // an ack racing a flush still owns the bus, so its words are drained and dropped
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state         <= IDLE;
         fs_q          <= 1'b0;
         flush         <= 1'b0;
         discard       <= 1'b0;
         next_addr     <= BASE_A;
         remaining     <= TOTAL_R;
         rd_burst_addr <= BASE_A;
         rd_burst_len  <= '0;
      end else begin
         state <= state_nx;
         fs_q  <= lcd_framesync;
         flush <= fs_q && !lcd_framesync;
         if (start) begin
            rd_burst_addr <= next_addr;
            rd_burst_len  <= 10'(remaining < BURST_R ? remaining : BURST_R);
         end
         if (flush) begin
            next_addr <= BASE_A;
            remaining <= TOTAL_R;
         end else if (accept) begin
            next_addr <= next_addr + ADDR_W'(rd_burst_len);
            remaining <= remaining - REM_W'(rd_burst_len);
         end
         discard <= state == XFER ? (rd_burst_done ? 1'b0 : discard || flush) : accept && flush;
      end

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= rd_data;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         lcd_data  <= '0;
         underflow <= 1'b0;
      end else begin
         lcd_data <= !lcd_request ? 16'h0000 : empty ? UNDERFLOW_RGB : mem[rd_ptr];
         if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            underflow <= 1'b0;
         end else begin
            wr_ptr    <= wr_ptr + PTR_W'(push);
            rd_ptr    <= rd_ptr + PTR_W'(pop);
            level     <= level + LVL_W'(push) - LVL_W'(pop);
            underflow <= underflow || (lcd_request && empty);
         end
      end

   assert property (@(posedge clk) disable iff (!rst_n) !(push && level == DEPTH_L))
      else $error("push into full prefetch fifo");

`ifdef LCD_PREFETCH_STATS_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         underflow_cnt  <= '0;
         fifo_min_level <= DEPTH_L;
      end else if (flush) begin
         underflow_cnt  <= '0;
         fifo_min_level <= DEPTH_L;
      end else begin
         if (lcd_request && empty && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
         if (lcd_request && level < fifo_min_level) fifo_min_level <= level;
      end
`endif
endmodule

// File: tb/tb_lcd_frame_prefetch.sv
// tb_lcd_frame_prefetch: directed checks of lcd_frame_prefetch against behavioural SDRAM responders.
module tb_lcd_frame_prefetch;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   logic        request = 1'b0, framesync = 1'b1, a_en = 1'b0;
   logic [15:0] a_data;
   logic        a_req, a_uf;
   logic [21:0] a_addr;
   logic [9:0]  a_len;
   logic        a_ack = 1'b0, a_valid = 1'b0, a_done = 1'b0;
   logic [15:0] a_rdata = '0, a_dat = '0;
   logic [21:0] a_log_addr [32];
   logic [9:0]  a_log_len [32];
   int          a_n = 0, a_cnt = 0, a_blen = 0;

   logic        b_request = 1'b0;
   logic [15:0] b_data;
   logic        b_req, b_uf;
   logic [21:0] b_addr;
   logic [9:0]  b_len;
   logic        b_ack = 1'b0, b_valid = 1'b0, b_done = 1'b0;
   logic [15:0] b_rdata = '0;
   logic [21:0] b_log_addr [32];
   logic [9:0]  b_log_len [32];
   int          b_n = 0, b_blen = 0;
`ifdef LCD_PREFETCH_STATS_EN
   logic [15:0] a_ucnt, b_ucnt;
   logic [3:0]  a_minlvl, b_minlvl;
`endif

   lcd_frame_prefetch #(.H_DISP(8), .V_DISP(2), .FRAME_BASE(32'h100), .BURST_LEN(4), .FIFO_DEPTH(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .lcd_request(request), .lcd_framesync(framesync), .lcd_data(a_data),
      .rd_burst_req(a_req), .rd_burst_addr(a_addr), .rd_burst_len(a_len), .rd_burst_ack(a_ack),
      .rd_data_valid(a_valid), .rd_data(a_rdata), .rd_burst_done(a_done), .underflow(a_uf)
`ifdef LCD_PREFETCH_STATS_EN
      , .underflow_cnt(a_ucnt), .fifo_min_level(a_minlvl)
`endif
   );

   lcd_frame_prefetch #(.H_DISP(5), .V_DISP(2), .FRAME_BASE(0), .BURST_LEN(4), .FIFO_DEPTH(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .lcd_request(b_request), .lcd_framesync(1'b1), .lcd_data(b_data),
      .rd_burst_req(b_req), .rd_burst_addr(b_addr), .rd_burst_len(b_len), .rd_burst_ack(b_ack),
      .rd_data_valid(b_valid), .rd_data(b_rdata), .rd_burst_done(b_done), .underflow(b_uf)
`ifdef LCD_PREFETCH_STATS_EN
      , .underflow_cnt(b_ucnt), .fifo_min_level(b_minlvl)
`endif
   );

   // SDRAM responder: ack two clocks after seeing a request, then stream counting words
   initial begin
      forever begin
         @(negedge clk);
         if (a_en && a_req) begin
            a_log_addr[a_n % 32] = a_addr;
            a_log_len[a_n % 32]  = a_len;
            a_n++;
            a_cnt  = 0;
            a_blen = int'(a_len);
            @(negedge clk);
            a_ack = 1'b1;
            @(negedge clk);
            a_ack = 1'b0;
            for (int i = 0; i < a_blen; i++) begin
               a_valid = 1'b1;
               a_rdata = a_dat;
               a_dat++;
               a_done  = (i == a_blen - 1);
               a_cnt   = i + 1;
               @(negedge clk);
            end
            a_valid = 1'b0;
            a_done  = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (b_req) begin
            b_log_addr[b_n % 32] = b_addr;
            b_log_len[b_n % 32]  = b_len;
            b_n++;
            b_blen = int'(b_len);
            @(negedge clk);
            b_ack = 1'b1;
            @(negedge clk);
            b_ack = 1'b0;
            for (int i = 0; i < b_blen; i++) begin
               b_valid = 1'b1;
               b_rdata = 16'(i);
               b_done  = (i == b_blen - 1);
               @(negedge clk);
            end
            b_valid = 1'b0;
            b_done  = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      int k;
      logic found;
      tick(3);
      check("rst_lcd_data", a_data, 16'h0);
      check("rst_req", a_req, 0);
      check("rst_addr", a_addr, 22'h100);
      check("rst_len", a_len, 0);
      check("rst_underflow", a_uf, 0);
      rst_n = 1'b1;
      tick(1);
      check("first_req", a_req, 1);
      check("first_addr", a_addr, 22'h100);
      check("first_len", a_len, 4);
      tick(2);
      check("req_held_no_ack", a_req, 1);
      // three requests against an empty FIFO
      request = 1'b1;
      tick(1);
      check("empty_pixel", a_data, 16'hF800);
      check("empty_underflow", a_uf, 1);
      tick(2);
      request = 1'b0;
      tick(1);
      check("idle_pixel", a_data, 16'h0);
      check("underflow_sticky", a_uf, 1);
      check("req_stable_addr", a_addr, 22'h100);
`ifdef LCD_PREFETCH_STATS_EN
      check("stats_ucnt", a_ucnt, 3);
      check("stats_minlvl", a_minlvl, 0);
`endif
      framesync = 1'b0;
      tick(1);
      check("pre_flush_req", a_req, 1);
      check("pre_flush_underflow", a_uf, 1);
      tick(1);
      check("flush_drops_req", a_req, 0);
      check("flush_clears_underflow", a_uf, 0);
`ifdef LCD_PREFETCH_STATS_EN
      check("flush_ucnt", a_ucnt, 0);
      check("flush_minlvl", a_minlvl, 8);
`endif
      tick(1);
      check("restart_req", a_req, 1);
      check("restart_addr", a_addr, 22'h100);
      check("restart_len", a_len, 4);
      framesync = 1'b1;
      // fill the FIFO, then drain the whole frame with spaced requests
      a_en = 1'b1;
      tick(40);
      check("fill_bursts", a_n, 2);
      check("fill_stalls_when_full", a_req, 0);
      b_request = 1'b1;
      for (int i = 0; i < 16; i++) begin
         request = 1'b1;
         tick(1);
         check($sformatf("pixel_%0d", i), a_data, 32'(i));
         check($sformatf("pixel_%0d_underflow", i), a_uf, 0);
         request = 1'b0;
         tick(2);
      end
      b_request = 1'b0;
      check("gap_pixel_zero", a_data, 16'h0);
      tick(10);
      check("frame_bursts", a_n, 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("burst_%0d_addr", i), a_log_addr[i], 22'h100 + 22'(4 * i));
         check($sformatf("burst_%0d_len", i), a_log_len[i], 4);
      end
      check("no_fifth_burst", a_req, 0);
      check("frame_underflow", a_uf, 0);
      request = 1'b1;
      tick(1);
      check("beyond_frame_pixel", a_data, 16'hF800);
      check("beyond_frame_underflow", a_uf, 1);
      request = 1'b0;
      // new frame; a second framesync lands while its first burst is half delivered
      a_dat = 16'h0020;
      framesync = 1'b0;
      tick(2);
      check("frame2_underflow_cleared", a_uf, 0);
      framesync = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         tick(1);
         found = (a_cnt == 2);
      end
      check("wait_xfer_word1", found, 1);
      k = a_n;
      framesync = 1'b0;
      tick(2);
      framesync = 1'b1;
      tick(40);
      check("after_abort_bursts", a_n, k + 2);
      check("after_abort_addr", a_log_addr[k % 32], 22'h100);
      check("after_abort_len", a_log_len[k % 32], 4);
      check("after_abort_addr2", a_log_addr[(k + 1) % 32], 22'h104);
      request = 1'b1;
      tick(1);
      check("new_frame_pixel0", a_data, 16'h0024);
      tick(1);
      check("new_frame_pixel1", a_data, 16'h0025);
      request = 1'b0;
      tick(1);
      check("new_frame_underflow", a_uf, 0);
      // ten-pixel frame splits into 4, 4, 2
      check("short_frame_bursts", b_n, 3);
      check("short_len0", b_log_len[0], 4);
      check("short_len1", b_log_len[1], 4);
      check("short_len2", b_log_len[2], 2);
      check("short_addr1", b_log_addr[1], 22'h4);
      check("short_addr2", b_log_addr[2], 22'h8);
      check("short_no_more", b_req, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/lcd_frame_prefetch.md
Name: lcd_frame_prefetch

Overview:
- Upstream feeder for the LCD timing driver.
- Fetches a frame from SDRAM with burst reads and buffers the pixels in an internal FIFO.
- Returns one 16-bit RGB565 pixel on lcd_data exactly one clock after each lcd_request, which matches the driver's one-clock-ahead request.
- Sits between the SDRAM controller's read-burst port and the LCD driver's user interface.

Parameters:
- H_DISP, 800, active pixels per line.
- V_DISP, 480, active lines per frame.
- FRAME_BASE, 0, SDRAM word address of pixel (0,0).
- ADDR_W, 22, SDRAM word-address width.
- BURST_LEN, 256, maximum words per read burst (1..FIFO_DEPTH/2).
- FIFO_DEPTH, 1024, buffer depth in words (power of two).
- UNDERFLOW_RGB, 16'hF800, pixel value driven when the FIFO is empty on request.

Ports:
- clk  in  1  pixel/system clock, shared with the LCD driver.
- rst_n  in  1  reset.
- lcd_request  in  1  pixel request from the LCD driver.
- lcd_framesync  in  1  frame sync from the LCD driver; low during vertical sync.
- lcd_data  out  16  pixel returned to the LCD driver.
- rd_burst_req  out  1  burst read request to the SDRAM controller.
- rd_burst_addr  out  ADDR_W  burst start word address.
- rd_burst_len  out  10  burst length in words.
- rd_burst_ack  in  1  request accepted, single-cycle pulse.
- rd_data_valid  in  1  rd_data carries a valid word.
- rd_data  in  16  SDRAM read word.
- rd_burst_done  in  1  last word of burst delivered, single-cycle pulse.
- underflow  out  1  sticky: a request found the FIFO empty in the current frame.

Clock and reset (already decided):
- One clock, clk.
- Reset rst_n is asynchronous, active-low.

Behaviour:
- Reset values:
  - lcd_data=0, rd_burst_req=0, rd_burst_addr=FRAME_BASE, rd_burst_len=0, underflow=0.
  - FIFO empty; FSM in IDLE.
  - Word counter remaining=H_DISP*V_DISP; next address=FRAME_BASE.
- Frame flush:
  - Triggered on the registered falling edge of lcd_framesync (flush pulse one cycle after the edge is sampled).
  - Clears the FIFO, underflow and discard.
  - Sets next address=FRAME_BASE and remaining=H_DISP*V_DISP.
  - Prefetch restarts at once, during vsync/back porch.
- FSM states IDLE, REQ, XFER:
  - IDLE->REQ when remaining>0, FIFO free space >= BURST_LEN and no flush this cycle.
    - Latch rd_burst_len=min(BURST_LEN,remaining) and rd_burst_addr=next address.
  - REQ: hold rd_burst_req=1 with stable address and length until rd_burst_ack.
    - On ack, go to XFER, advance next address and remaining by rd_burst_len.
  - XFER: each rd_data_valid pushes rd_data into the FIFO unless discard=1.
    - rd_burst_done->IDLE.
- Flush while in REQ: drop the request (rd_burst_req=0 next cycle), go to IDLE.
  - If ack and flush coincide, the burst counts as accepted: enter XFER with discard=1.
- Flush while in XFER: set discard=1. Remaining words are dropped, not pushed. On rd_burst_done clear discard and go to IDLE. The counters are already re-initialised by the flush.
- Output path:
  - On a cycle with lcd_request=1 and FIFO non-empty: pop, and lcd_data<=head word on the next clock.
  - On lcd_request=1 and FIFO empty: lcd_data<=UNDERFLOW_RGB, underflow<=1, nothing popped.
  - On lcd_request=0: lcd_data<=0.
  - Latency: exactly 1 clock from request to data.
- Simultaneous events:
  - Push and pop in the same cycle: fill level unchanged.
  - Pop has no FIFO-full interaction, because free-space gating prevents overflow.
  - A push when full is a design error; flag it with an assertion in simulation.
- Arithmetic:
  - Address advance is modulo 2^ADDR_W.
  - remaining is wide enough for H_DISP*V_DISP.
  - FIFO level counter is log2(FIFO_DEPTH)+1 bits.
- Requests beyond the frame's pixel count, for example from a mismatched driver, are treated as underflow.

Optional Feature:
- Macro: LCD_PREFETCH_STATS_EN.
- With the macro:
  - Extra output port underflow_cnt [15:0]: count of requests served while the FIFO was empty.
  - Saturates at 16'hFFFF; cleared by reset and by frame flush.
  - Extra output fifo_min_level [log2(FIFO_DEPTH):0]: lowest FIFO level seen while lcd_request=1 since the last flush.
  - fifo_min_level resets to FIFO_DEPTH.
- Without the macro: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Params H_DISP=8, V_DISP=2, BURST_LEN=4, FIFO_DEPTH=8, FRAME_BASE=0x100 for the first four scenarios.
- Reset and flush, SDRAM model with ack after 2 clks and data 0x0000..0x000F -> bursts at 0x100, 0x104, 0x108, 0x10C, each len 4; no fifth burst; remaining=0.
- Request pulses 16 cycles after the FIFO fills -> lcd_data 0x0000..0x000F, each one clock after its request; underflow stays 0.
- Request while the FIFO is empty (SDRAM model never acks) -> lcd_data=16'hF800 one clock later; underflow=1; cleared by the next framesync falling edge.
- Framesync falls mid-XFER after 2 of 4 words -> remaining 2 words discarded; the next burst has addr 0x100, len 4; the FIFO holds only new-frame data.
- H_DISP*V_DISP=10, BURST_LEN=4 -> burst lengths 4, 4, 2.
- Stats build with 3 empty-FIFO requests -> underflow_cnt=3; reset to 0 on flush. Non-stats build compiles with the extra ports absent.
